// File: rtl/arm_seq_alu.sv
// arm_seq_alu: registered ARM-style ALU with barrel-shifted second operand,
// NZCV flag generation and an iterative shift-and-add multiplier.
// Single-cycle ops complete one cycle after the accepting edge; MUL holds
// busy for WIDTH/MUL_STEP cycles and signals done on the following cycle.
//
// Optional build macro: ARM_SEQ_ALU_MUL_EARLY_EXIT_EN
//   When defined, MUL finishes as soon as the remaining multiplier bits are
//   all zero (minimum one busy cycle). The result is identical either way.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready; accepts start, 1-cycle ops retire straight from here
// ST_MULT | multiply in progress, busy=1, start requests are ignored

module arm_seq_alu #(
    parameter  int WIDTH    = 32,
    parameter  int MUL_STEP = 1,
    localparam int SHW      = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [1:0]       sh,
    input  logic [SHW-1:0]   shamt,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       flags_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam int STEPS = WIDTH / MUL_STEP;
    localparam int CNTW  = $clog2(STEPS + 1);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_RSB = 4'b0011;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_BIC = 4'b1110;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MULT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [1:0]       cv_q, cv_d;

    logic [WIDTH-1:0] sb;
    logic             sh_c;
    logic [WIDTH-1:0] sh_tmp;
    logic [SHW:0]     rot_amt;

    logic [WIDTH-1:0] add_x, add_y;
    logic             add_ci;
    logic [WIDTH:0]   sum;
    logic             add_v;

    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v, alu_pass;
    logic [3:0]       alu_flags;

    logic [WIDTH-1:0] partial;
    logic [WIDTH-1:0] acc_nx, mcand_nx, mplier_nx;
    logic             mul_last;

    // Barrel shifter; shifting by amt-1 first exposes the last bit shifted out.
    always_comb begin
        sb      = b;
        sh_c    = flags_in[1];
        sh_tmp  = b;
        rot_amt = (SHW+1)'(WIDTH) - {1'b0, shamt};
        if (shamt != '0) begin
            case (sh)
                SH_LSL: begin
                    sh_tmp = b << (shamt - SHW'(1));
                    sh_c   = sh_tmp[WIDTH-1];
                    sb     = sh_tmp << 1;
                end
                SH_LSR: begin
                    sh_tmp = b >> (shamt - SHW'(1));
                    sh_c   = sh_tmp[0];
                    sb     = sh_tmp >> 1;
                end
                SH_ASR: begin
                    sh_tmp = $signed(b) >>> (shamt - SHW'(1));
                    sh_c   = sh_tmp[0];
                    sb     = $signed(sh_tmp) >>> 1;
                end
                SH_ROR: begin
                    sb   = (b >> shamt) | (b << rot_amt);
                    sh_c = sb[WIDTH-1];
                end
                default: ;
            endcase
        end
    end

    // Shared WIDTH+1 adder; subtraction is done as x + ~y + carry.
    always_comb begin
        add_x  = a;
        add_y  = sb;
        add_ci = 1'b0;
        case (op)
            OP_SUB: begin
                add_y  = ~sb;
                add_ci = 1'b1;
            end
            OP_RSB: begin
                add_x  = sb;
                add_y  = ~a;
                add_ci = 1'b1;
            end
            OP_ADC: add_ci = flags_in[1];
            OP_SBC: begin
                add_y  = ~sb;
                add_ci = flags_in[1];
            end
            default: ;
        endcase
        sum   = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_ci};
        add_v = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (sum[WIDTH-1] != add_x[WIDTH-1]);
    end

    // Single-cycle result and flag selection; unknown codes pass flags through.
    always_comb begin
        alu_res  = '0;
        alu_c    = sh_c;
        alu_v    = flags_in[0];
        alu_pass = 1'b0;
        case (op)
            OP_AND: alu_res = a & sb;
            OP_EOR: alu_res = a ^ sb;
            OP_ORR: alu_res = a | sb;
            OP_MOV: alu_res = sb;
            OP_BIC: alu_res = a & ~sb;
            OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = add_v;
            end
            default: alu_pass = 1'b1;
        endcase
        if (alu_pass) begin
            alu_flags = flags_in;
        end else begin
            alu_flags = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
        end
    end

    // One multiply step: add the multiplicand for each retired multiplier bit.
    always_comb begin
        partial = '0;
        for (int k = 0; k < MUL_STEP; k++) begin
            if (mplier_q[k]) begin
                partial = partial + (mcand_q << k);
            end
        end
        acc_nx    = acc_q + partial;
        mcand_nx  = mcand_q << MUL_STEP;
        mplier_nx = mplier_q >> MUL_STEP;
`ifdef ARM_SEQ_ALU_MUL_EARLY_EXIT_EN
        mul_last  = (cnt_q == CNTW'(1)) || (mplier_nx == '0);
`else
        mul_last  = (cnt_q == CNTW'(1));
`endif
    end

    // Sequencer next-state: accept in IDLE, iterate in MULT, retire on last step.
    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        result_d = result_q;
        flags_d  = flags_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        cv_d     = cv_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (op == OP_MUL) begin
                        state_d  = ST_MULT;
                        acc_d    = '0;
                        mcand_d  = a;
                        mplier_d = b;
                        cnt_d    = CNTW'(STEPS);
                        cv_d     = flags_in[1:0];
                    end else begin
                        result_d = alu_res;
                        flags_d  = alu_flags;
                        done_d   = 1'b1;
                    end
                end
            end
            ST_MULT: begin
                acc_d    = acc_nx;
                mcand_d  = mcand_nx;
                mplier_d = mplier_nx;
                cnt_d    = cnt_q - CNTW'(1);
                if (mul_last) begin
                    state_d  = ST_IDLE;
                    result_d = acc_nx;
                    flags_d  = {acc_nx[WIDTH-1], (acc_nx == '0), cv_q};
                    done_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any multiply in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            done_q   <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            cv_q     <= '0;
        end else begin
            state_q  <= state_d;
            done_q   <= done_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            cv_q     <= cv_d;
        end
    end

    assign busy   = (state_q == ST_MULT);
    assign done   = done_q;
    assign result = result_q;
    assign flags  = flags_q;

endmodule

// File: tb/tb_arm_seq_alu.sv
// Randomized self-checking bench for arm_seq_alu (WIDTH=32, MUL_STEP=1).
module tb_arm_seq_alu;

    localparam int W        = 32;
    localparam int MUL_STEP = 1;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [1:0]  sh;
    logic [4:0]  shamt;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  flags_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [3:0]  flags;

    int checks   = 0;
    int failures = 0;

    arm_seq_alu #(.WIDTH(W), .MUL_STEP(MUL_STEP)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .sh       (sh),
        .shamt    (shamt),
        .a        (a),
        .b        (b),
        .flags_in (flags_in),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .flags    (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Expected cycles from accepting edge to done for a MUL with multiplier b.
    function automatic int mul_lat(input logic [31:0] bv);
`ifdef ARM_SEQ_ALU_MUL_EARLY_EXIT_EN
        int n;
        n = 0;
        for (int i = 0; i < W; i++) if (bv[i]) n = i + 1;
        n = (n + MUL_STEP - 1) / MUL_STEP;
        if (n < 1) n = 1;
        return n + 1;
`else
        return W / MUL_STEP + 1;
`endif
    endfunction

    // Reference model in plain 64-bit arithmetic.
    task automatic model(input logic [3:0] o, input logic [1:0] s, input logic [4:0] amt,
                         input logic [31:0] av, input logic [31:0] bv, input logic [3:0] fin,
                         output logic [31:0] r, output logic [3:0] f);
        logic [31:0]     sbv;
        logic            sc, c, v;
        logic [63:0]     w;
        longint unsigned ua, ub, ur;
        longint          sa, ssb, sr;
        longint          cin;
        sbv = bv;
        sc  = fin[1];
        if (amt != 0) begin
            case (s)
                2'd0: begin w = {32'b0, bv} << amt; sbv = w[31:0];  sc = w[32]; end
                2'd1: begin w = {bv, 32'b0} >> amt; sbv = w[63:32]; sc = w[31]; end
                2'd2: begin w = $signed({bv, 32'b0}) >>> amt; sbv = w[63:32]; sc = w[31]; end
                default: begin w = {bv, bv} >> amt; sbv = w[31:0]; sc = sbv[31]; end
            endcase
        end
        ua  = {32'b0, av};
        ub  = {32'b0, sbv};
        sa  = longint'($signed(av));
        ssb = longint'($signed(sbv));
        cin = fin[1] ? 64'sd1 : 64'sd0;
        c   = sc;
        v   = fin[0];
        sr  = 0;
        r   = 32'h0;
        case (o)
            4'b0000: r = av & sbv;
            4'b0001: r = av ^ sbv;
            4'b1100: r = av | sbv;
            4'b1101: r = sbv;
            4'b1110: r = av & ~sbv;
            4'b0100: begin ur = ua + ub;       r = ur[31:0]; c = (ur > 64'hFFFF_FFFF); sr = sa + ssb; end
            4'b0101: begin ur = ua + ub + longint'(cin); r = ur[31:0]; c = (ur > 64'hFFFF_FFFF); sr = sa + ssb + cin; end
            4'b0010: begin r = av - sbv; c = (ua >= ub); sr = sa - ssb; end
            4'b0011: begin r = sbv - av; c = (ub >= ua); sr = ssb - sa; end
            4'b0110: begin r = av - sbv - 32'(1 - cin); c = (ua >= ub + longint'(1 - cin)); sr = sa - ssb - (1 - cin); end
            4'b1000: begin
                ur = {32'b0, av} * {32'b0, bv};
                r  = ur[31:0];
                c  = fin[1];
                v  = fin[0];
            end
            default: begin
                r = 32'h0;
                f = fin;
                return;
            end
        endcase
        if (o inside {4'b0100, 4'b0101, 4'b0010, 4'b0011, 4'b0110})
            v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        f = {r[31], (r == 32'h0), c, v};
    endtask

    // Called at a negedge: drive a request, scramble inputs after acceptance,
    // then wait (bounded) for done. Returns at the negedge where done is seen.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [1:0] s,
                          input logic [4:0] amt, input logic [31:0] av, input logic [31:0] bv,
                          input logic [3:0] fin, input logic [31:0] exp_r, input logic [3:0] exp_f,
                          input int exp_lat, input bit noise);
        int  lat, busy_cnt;
        bit  got;
        start = 1'b1; op = o; sh = s; shamt = amt; a = av; b = bv; flags_in = fin;
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 4'($urandom); a = $urandom; b = $urandom; flags_in = 4'($urandom);
        sh = 2'($urandom); shamt = 5'($urandom);
        lat = 0; busy_cnt = 0; got = 0;
        while (!got && lat < 200) begin
            @(negedge clk);
            lat++;
            if (done) begin
                got = 1;
            end else begin
                if (busy) busy_cnt++;
                if (noise) begin
                    start = 1'($urandom);
                    op    = 4'($urandom);
                    a     = $urandom;
                    b     = $urandom;
                end
            end
        end
        start = 1'b0;
        chk({tag, "_done"}, 64'(got), 64'd1);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        chk({tag, "_result"}, 64'(result), 64'(exp_r));
        chk({tag, "_flags"}, 64'(flags), 64'(exp_f));
        if (exp_lat > 1) chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat - 1));
    endtask

    task automatic run_rand(input string tag, input logic [3:0] o, input logic [1:0] s,
                            input logic [4:0] amt, input logic [31:0] av, input logic [31:0] bv,
                            input logic [3:0] fin);
        logic [31:0] er;
        logic [3:0]  ef;
        model(o, s, amt, av, bv, fin, er, ef);
        run_op(tag, o, s, amt, av, bv, fin, er, ef, (o == 4'b1000) ? mul_lat(bv) : 1, (o == 4'b1000));
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] last_r;
        logic [3:0]  last_f;
        reset = 1'b0; start = 1'b0; op = 4'h0; sh = 2'b00; shamt = 5'd0;
        a = 32'h0; b = 32'h0; flags_in = 4'h0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_flags", 64'(flags), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        run_op("add_ovf", 4'b0100, 2'b00, 5'd0, 32'h7FFF_FFFF, 32'h1, 4'b0000, 32'h8000_0000, 4'b1001, 1, 0);
        run_op("sub_eq", 4'b0010, 2'b00, 5'd0, 32'd5, 32'd5, 4'b0000, 32'h0, 4'b0110, 1, 0);
        run_op("sbc_eq", 4'b0110, 2'b00, 5'd0, 32'd5, 32'd5, 4'b0000, 32'hFFFF_FFFF, 4'b1000, 1, 0);
        run_op("orr_asr", 4'b1100, 2'b10, 5'd4, 32'h0, 32'h8000_0018, 4'b0001, 32'hF800_0001, 4'b1011, 1, 0);
        run_op("orr_sh0", 4'b1100, 2'b01, 5'd0, 32'h0, 32'h5, 4'b0010, 32'h5, 4'b0010, 1, 0);
        run_op("undef_op", 4'b0111, 2'b00, 5'd0, 32'h1234, 32'h5678, 4'b1010, 32'h0, 4'b1010, 1, 0);
        run_op("mul_big", 4'b1000, 2'b11, 5'd7, 32'd3, 32'hFFFF_FFFF, 4'b0011, 32'hFFFF_FFFD, 4'b1011, mul_lat(32'hFFFF_FFFF), 1);
        run_op("mul_b2", 4'b1000, 2'b00, 5'd0, 32'd3, 32'd2, 4'b0000, 32'd6, 4'b0000, mul_lat(32'd2), 0);
        run_op("b2b_add", 4'b0100, 2'b00, 5'd0, 32'd10, 32'd20, 4'b0000, 32'd30, 4'b0000, 1, 0);
        @(negedge clk);
        chk("idle_done_low", 64'(done), 64'd0);
        chk("idle_result_hold", 64'(result), 64'd30);

        // Reset in the middle of a MUL aborts it.
        start = 1'b1; op = 4'b1000; a = 32'd3; b = 32'hFFFF_FFFF; flags_in = 4'b0011;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_done", 64'(done), 64'd0);
        chk("mrst_result", 64'(result), 64'd0);
        chk("mrst_flags", 64'(flags), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mrst_no_resume", 64'(busy | done), 64'd0);
        run_op("post_rst_add", 4'b0100, 2'b00, 5'd0, 32'd2, 32'd3, 4'b0000, 32'd5, 4'b0000, 1, 0);

        last_r = result;
        last_f = flags;
        for (int i = 0; i < 300; i++) begin
            logic [3:0]  ro;
            logic [1:0]  rs;
            logic [4:0]  ramt;
            logic [31:0] ra, rb;
            logic [3:0]  rf;
            ro   = 4'($urandom);
            rs   = 2'($urandom);
            ramt = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            ra   = pick_val();
            rb   = pick_val();
            rf   = 4'($urandom);
            if (ro == 4'b1000 && $urandom_range(0, 2) == 0) rb = 32'($urandom_range(0, 255));
            run_rand($sformatf("rnd%0d_op%0h", i, ro), ro, rs, ramt, ra, rb, rf);
            last_r = result;
            last_f = flags;
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                chk("rnd_idle_done", 64'(done), 64'd0);
                chk("rnd_idle_hold", 64'({last_f, last_r}), 64'({flags, result}) & 64'h0 | 64'({last_f, last_r}) & 64'h0 | 64'({flags, result}));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
